pulse_meter: RTL and testbench

- Receive-side counterpart of the LA-controlled pulse generator.
- Samples an asynchronous pulse train, e.g. the generator output looped back or a pad input.
- Measures active-phase width and lead-to-lead period in clock cycles, and counts pulses.
- Control comes from LA inputs. Results, valid and status go to LA outputs for firmware readback and self-check of the generator.

---
 rtl/pulse_meter.sv | 185 ++++++++++++++++++
 tb/tb_pulse_meter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// Pulse width / period / count meter for an asynchronous pulse train.
// Samples pulse_in through a synchronizer and times it in wb_clk_i cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | disarmed, results held
// WAIT_LEAD | armed, waiting for the first leading edge
// ACTIVE    | inside the active phase, width and period counting
// INACTIVE  | inside the inactive phase, period counting
// DONE      | one-shot result captured, held until meas_en drops
module pulse_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             pulse_in,
  input  logic             meas_en,
  input  logic             meas_clr,
  input  logic             pol,
  input  logic             single,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] pulse_cnt_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             ovf_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LEAD,
    ACTIVE,
    INACTIVE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pol_q;
  logic                   arm_q;
  logic [CNT_W-1:0]       wcnt_q;
  logic [CNT_W-1:0]       prd_q;
  logic [CNT_W-1:0]       shadow_q;
  logic [CNT_W-1:0]       width_q;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       pcnt_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   ovf_q;

  logic s_cur;
  logic s_prev;
  logic lead;
  logic trail;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  assign s_cur  = sync_q[SYNC_STAGES-1] ^ pol_q;
  assign s_prev = hist_q ^ pol_q;
  assign lead   = s_cur & ~s_prev;
  assign trail  = ~s_cur & s_prev;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      pol_q    <= 1'b0;
      arm_q    <= 1'b0;
      wcnt_q   <= '0;
      prd_q    <= '0;
      shadow_q <= '0;
      width_q  <= '0;
      period_q <= '0;
      pcnt_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      arm_q   <= 1'b0;
      if (meas_clr) begin
        wcnt_q   <= '0;
        prd_q    <= '0;
        shadow_q <= '0;
        width_q  <= '0;
        period_q <= '0;
        pcnt_q   <= '0;
        ovf_q    <= 1'b0;
        if (meas_en) begin
          state_q <= WAIT_LEAD;
          busy_q  <= 1'b1;
          arm_q   <= 1'b1;
          pol_q   <= pol;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else if (!meas_en) begin
        // abort discards the partial measurement, results stay as they were
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= WAIT_LEAD;
            busy_q  <= 1'b1;
            arm_q   <= 1'b1;
            pol_q   <= pol;
          end
          WAIT_LEAD: begin
            if (lead && !arm_q) begin
              state_q <= ACTIVE;
              wcnt_q  <= ONE;
              prd_q   <= ONE;
              pcnt_q  <= sat_inc(pcnt_q);
              ovf_q   <= ovf_q | (pcnt_q == MAX);
            end
          end
          ACTIVE: begin
            prd_q <= sat_inc(prd_q);
            if (trail) begin
              shadow_q <= wcnt_q;
              state_q  <= INACTIVE;
              ovf_q    <= ovf_q | (prd_q == MAX);
            end else begin
              wcnt_q <= sat_inc(wcnt_q);
              ovf_q  <= ovf_q | (prd_q == MAX) | (wcnt_q == MAX);
            end
          end
          INACTIVE: begin
            if (lead) begin
              width_q  <= shadow_q;
              period_q <= prd_q;
              valid_q  <= 1'b1;
              wcnt_q   <= ONE;
              prd_q    <= ONE;
              pcnt_q   <= sat_inc(pcnt_q);
              ovf_q    <= ovf_q | (pcnt_q == MAX);
              if (single) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ACTIVE;
              end
            end else begin
              prd_q <= sat_inc(prd_q);
              ovf_q <= ovf_q | (prd_q == MAX);
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign width_o     = width_q;
  assign period_o    = period_q;
  assign pulse_cnt_o = pcnt_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: expected results are queued by the stimulus
// and popped by per-instance monitors whenever valid_o strobes.
module tb_pulse_meter;

  typedef struct {
    int w;
    int p;
    int gap;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        pulse_in, meas_en, meas_clr, pol, single;
  logic [15:0] width_o, period_o, pulse_cnt_o;
  logic        valid_o, busy_o, ovf_o;

  logic        pulse4, en4, clr4;
  logic [3:0]  width4, period4, pcnt4;
  logic        valid4, busy4, ovf4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int last_cyc4 = 0;
  exp_t sb[$];
  exp_t sb4[$];

  pulse_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .pulse_in(pulse_in), .meas_en(meas_en),
    .meas_clr(meas_clr), .pol(pol), .single(single), .width_o(width_o),
    .period_o(period_o), .pulse_cnt_o(pulse_cnt_o), .valid_o(valid_o),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  pulse_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .pulse_in(pulse4), .meas_en(en4),
    .meas_clr(clr4), .pol(1'b0), .single(1'b0), .width_o(width4),
    .period_o(period4), .pulse_cnt_o(pcnt4), .valid_o(valid4),
    .busy_o(busy4), .ovf_o(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      step(hi);
      pulse_in = 1'b0;
      step(lo);
    end
  endtask

  task automatic pulses4(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      pulse4 = 1'b1;
      step(hi);
      pulse4 = 1'b0;
      step(lo);
    end
  endtask

  task automatic push(input int w, input int p, input int gap);
    exp_t e;
    e.w = w; e.p = p; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push4(input int w, input int p, input int gap);
    exp_t e;
    e.w = w; e.p = p; e.gap = gap;
    sb4.push_back(e);
  endtask

  task automatic disarm_and_clear();
    meas_en = 1'b0;
    step(2);
    meas_clr = 1'b1;
    step(1);
    meas_clr = 1'b0;
    chk("clear_pulse_cnt", pulse_cnt_o, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got width %0d period %0d, expected no valid", width_o, period_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("width", width_o, e.w);
        chk("period", period_o, e.p);
        if (e.gap != 0) chk("valid_spacing", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid4) begin
      if (sb4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid4: got width %0d period %0d, expected no valid", width4, period4);
      end else begin
        exp_t e;
        e = sb4.pop_front();
        chk("width4", width4, e.w);
        chk("period4", period4, e.p);
        if (e.gap != 0) chk("valid_spacing4", cyc - last_cyc4, e.gap);
      end
      last_cyc4 = cyc;
    end
  end

  initial begin
    rst_n = 1'b0; pulse_in = 1'b0; meas_en = 1'b1; meas_clr = 1'b0;
    pol = 1'b0; single = 1'b0;
    pulse4 = 1'b0; en4 = 1'b0; clr4 = 1'b0;

    // reset held with activity on the inputs
    repeat (6) begin
      @(posedge clk);
      #1 pulse_in = ~pulse_in;
    end
    chk("rst_width", width_o, 0);
    chk("rst_period", period_o, 0);
    chk("rst_pulse_cnt", pulse_cnt_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", ovf_o, 0);
    rst_n = 1'b1;
    #1 chk("busy_before_arm", busy_o, 0);
    step(1);
    chk("busy_after_arm", busy_o, 1);

    // continuous, active-high, 5 high / 7 low
    disarm_and_clear();
    pol = 1'b0; single = 1'b0; meas_en = 1'b1;
    step(3);
    push(5, 12, 0);
    for (int i = 0; i < 4; i++) push(5, 12, 12);
    pulses(6, 5, 7);
    step(4);
    chk("cont_pulse_cnt", pulse_cnt_o, 6);
    chk("cont_busy", busy_o, 1);
    chk("cont_ovf", ovf_o, 0);
    meas_en = 1'b0;
    step(2);
    chk("disarm_busy", busy_o, 0);
    chk("disarm_width_hold", width_o, 5);
    chk("disarm_period_hold", period_o, 12);

    // same waveform, active-low
    disarm_and_clear();
    pol = 1'b1; meas_en = 1'b1;
    step(3);
    push(7, 12, 0);
    push(7, 12, 12);
    push(7, 12, 12);
    pulses(4, 5, 7);
    step(4);
    chk("pol1_pulse_cnt", pulse_cnt_o, 4);
    meas_en = 1'b0;
    pol = 1'b0;

    // one-shot, then rearm
    disarm_and_clear();
    single = 1'b1; meas_en = 1'b1;
    step(3);
    push(5, 12, 0);
    pulses(5, 5, 7);
    step(4);
    chk("single_busy", busy_o, 0);
    chk("single_pulse_cnt", pulse_cnt_o, 2);
    chk("single_width_hold", width_o, 5);
    chk("single_period_hold", period_o, 12);
    meas_en = 1'b0;
    step(2);
    meas_en = 1'b1;
    step(3);
    chk("rearm_busy", busy_o, 1);
    push(5, 12, 0);
    pulses(3, 5, 7);
    step(4);
    chk("rearm_pulse_cnt", pulse_cnt_o, 4);
    chk("rearm_busy_done", busy_o, 0);
    single = 1'b0;

    // armed while already active, then clear mid-ACTIVE
    disarm_and_clear();
    pulse_in = 1'b1;
    step(5);
    meas_en = 1'b1;
    step(5);
    chk("prehigh_no_lead", pulse_cnt_o, 0);
    pulse_in = 1'b0;
    step(7);
    pulse_in = 1'b1;
    step(6);
    chk("midactive_pulse_cnt", pulse_cnt_o, 1);
    meas_clr = 1'b1;
    step(1);
    meas_clr = 1'b0;
    chk("clr_pulse_cnt", pulse_cnt_o, 0);
    chk("clr_width", width_o, 0);
    chk("clr_period", period_o, 0);
    chk("clr_busy", busy_o, 1);
    step(4);
    pulse_in = 1'b0;
    step(7);
    push(5, 12, 0);
    pulses(2, 5, 7);
    step(4);
    chk("after_clr_pulse_cnt", pulse_cnt_o, 2);
    meas_en = 1'b0;
    step(2);

    // saturation on the 4-bit instance
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
    en4 = 1'b1;
    step(3);
    push4(15, 15, 0);
    push4(5, 12, 12);
    push4(5, 12, 12);
    pulses4(1, 20, 5);
    pulses4(3, 5, 7);
    step(4);
    chk("sat_ovf", ovf4, 1);
    chk("sat_pulse_cnt", pcnt4, 4);
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
    chk("sat_ovf_cleared", ovf4, 0);
    chk("sat_width_cleared", width4, 0);
    en4 = 1'b0;
    step(3);

    chk("sb_drained", sb.size(), 0);
    chk("sb4_drained", sb4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
